jtframe_sys_ctrl: RTL and testbench
===================================

Name: jtframe_sys_ctrl

Overview:
- System-control block between the PLL and the jtframe_mister glue.
- Supervises PLL lock and produces a PLL re-lock reset pulse.
- Sequences the system and game resets.
- Decodes OSD status bits into DIP/sound controls, drives the LED, and optionally drives the SNAC/DB15 user-port control pins.
- Single clock domain (clk_sys). Reset is synchronous, active-high.

Parameters:
- RST_CNT, 16: extra clk_sys cycles that rst_n stays low after every reset source clears.
- GAME_DLY, 256: clk_sys cycles that game_rst stays high after the system reset and downloading both clear. Range 1..65535.

Ports:
- clk_sys  in  1  system clock
- rst  in  1  synchronous active-high reset (top-level RESET)
- pll_locked  in  1  PLL lock indicator, already in the clk_sys domain
- status  in  32  OSD status word
- buttons  in  2  board buttons; bit 1 = reset request
- key_pause  in  1  one-cycle pulse that toggles pause
- downloading  in  1  ROM download in progress
- joy_clk  in  1  DB15 reader clock
- joy_load  in  1  DB15 reader load strobe
- pll_rst  out  1  reset to PLL
- rst_n  out  1  system reset, active-low
- game_rst  out  1  game reset, active-high
- game_rst_n  out  1  inverse of game_rst
- enable_fm  out  1  FM enable
- enable_psg  out  1  PSG enable
- dip_test  out  1  test mode, active-low
- dip_pause  out  1  pause, active-low
- dip_flip  out  1  flip screen
- dip_fxlevel  out  2  FX volume level
- LED  out  1  user LED
- USER_OUT  out  7  user-port outputs
- USER_MODE  out  1  user-port mode

Behaviour:
Reset values: every output below is its value while rst is high. All outputs are registered.
- pll_rst = 0, rst_n = 0, game_rst = 1, game_rst_n = 0.
- enable_fm = 1, enable_psg = 1, dip_test = 1, dip_pause = 1, dip_flip = 0, dip_fxlevel = 2'b10.
- LED = 0, USER_OUT = 7'h7F, USER_MODE = 0.
- Internal: last_locked = 0, pll counter = 8'hD0, pause_state = 0.

PLL supervisor:
- Each cycle, last_locked <= pll_locked.
- Falling lock (last_locked = 1 and pll_locked = 0): counter <= 8'hFF, pll_rst <= 1.
- Otherwise: if the counter is nonzero it decrements; if it is zero, pll_rst <= 0.
- Result: pll_rst is high for exactly 256 cycles after each detected falling edge.
- A new falling edge while pll_rst is high reloads the counter to 8'hFF.
- The post-reset count from 8'hD0 counts down harmlessly with pll_rst = 0.

System reset:
- src = rst | ~pll_locked | pll_rst | status[0] | buttons[1].
- While src is high, rst_n = 0 and a counter loads RST_CNT.
- Once src is low, the counter decrements. rst_n goes to 1 on the cycle after it reaches 0.
- Any reassertion of src restarts the sequence.

Game reset:
- g = ~rst_n | downloading.
- While g is high, game_rst = 1 and a counter loads GAME_DLY.
- Once g is low, the counter decrements. game_rst clears on the cycle after it reaches 0.
- game_rst_n = ~game_rst in the same register stage.

DIP decode: one cycle of latency from status.
- enable_fm = ~status[8]
- enable_psg = ~status[7]
- dip_test = ~status[6]
- dip_flip = status[12]
- dip_fxlevel = status[11:10] ^ 2'b10, so OSD index 0→2, 1→3, 2→0, 3→1.

Pause:
- key_pause toggles pause_state.
- pause_state is cleared while game_rst is high; key_pause is ignored during game_rst.
- dip_pause = ~pause_state.

LED:
- LED = downloading, registered.

Optional Feature:
JTFRAME_DB15_EN
- Defined:
  - USER_MODE = |status[31:30].
  - USER_OUT = USER_MODE ? {5'b11111, joy_clk, joy_load} : 7'h7F.
  - Both registered, one cycle of latency.
- Undefined:
  - USER_MODE is constant 0 and USER_OUT is constant 7'h7F.
  - joy_clk, joy_load and status[31:30] are unused.

Test Plan:
- Release rst with pll_locked = 1 and status = 0 → pll_rst stays 0. rst_n rises RST_CNT+1 cycles after release. game_rst falls GAME_DLY+1 cycles after rst_n rises.
- With pll_locked steady at 1, drop it to 0 for one cycle → pll_rst high for exactly 256 cycles. rst_n low throughout, then the full reset sequence replays.
- Pulse buttons[1] for one cycle mid-run → rst_n low, then the RST_CNT delay; game_rst reasserts and releases GAME_DLY+1 cycles after rst_n rises. Raise downloading for 10 cycles → game_rst stays high until GAME_DLY+1 cycles after downloading falls; LED tracks downloading with one cycle of delay.
- status[11:10] = 0,1,2,3 → dip_fxlevel = 2,3,0,1. status[8:6] = 3'b111 → enable_fm = 0, enable_psg = 0, dip_test = 0. status[12] = 1 → dip_flip = 1.
- Two key_pause pulses outside reset → dip_pause goes 0, then 1. A pulse during game_rst → no change.
- JTFRAME_DB15_EN defined, status[30] = 1, joy_clk = 1, joy_load = 0 → USER_MODE = 1, USER_OUT = 7'b1111110. status[31:30] = 0 → USER_OUT = 7'h7F, USER_MODE = 0.

Source files
------------

// File: rtl/jtframe_sys_ctrl.sv
// System control between the PLL and the MiSTer glue: PLL re-lock reset, reset sequencing,
// OSD DIP decode, pause, LED. Define JTFRAME_DB15_EN to drive the SNAC/DB15 user-port pins.
module jtframe_sys_ctrl #(
    parameter int unsigned RST_CNT  = 16,
    parameter int unsigned GAME_DLY = 256
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        pll_locked,
    input  logic [31:0] status,
    input  logic [1:0]  buttons,
    input  logic        key_pause,
    input  logic        downloading,
    input  logic        joy_clk,
    input  logic        joy_load,
    output logic        pll_rst,
    output logic        rst_n,
    output logic        game_rst,
    output logic        game_rst_n,
    output logic        enable_fm,
    output logic        enable_psg,
    output logic        dip_test,
    output logic        dip_pause,
    output logic        dip_flip,
    output logic [1:0]  dip_fxlevel,
    output logic        LED,
    output logic [6:0]  USER_OUT,
    output logic        USER_MODE
);

    localparam int unsigned PW = 8;
    localparam int unsigned RW = (RST_CNT < 2) ? 1 : $clog2(RST_CNT + 1);
    localparam int unsigned GW = 16;

    logic          last_locked;
    logic [PW-1:0] pll_cnt;
    logic [RW-1:0] rst_cnt;
    logic [GW-1:0] game_cnt;
    logic          pause_state;
    logic          sys_src_c;
    logic          game_src_c;
    logic          pause_nxt_c;
    logic          unused_bits;

    assign sys_src_c   = ~pll_locked | pll_rst | status[0] | buttons[1];
    assign game_src_c  = ~rst_n | downloading;
    assign pause_nxt_c = game_rst ? 1'b0 : (pause_state ^ key_pause);
    assign unused_bits = ^{status[29:13], status[9], status[5:1], buttons[0]};

    // A falling lock edge holds pll_rst for 256 cycles; a new edge restarts the window
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            last_locked <= 1'b0;
            pll_cnt     <= PW'(8'hD0);
            pll_rst     <= 1'b0;
        end else begin
            last_locked <= pll_locked;
            if (last_locked && !pll_locked) begin
                pll_cnt <= PW'(8'hFF);
                pll_rst <= 1'b1;
            end else if (pll_cnt != '0) begin
                pll_cnt <= pll_cnt - PW'(1);
            end else begin
                pll_rst <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst || sys_src_c) begin
            rst_n   <= 1'b0;
            rst_cnt <= RW'(RST_CNT);
        end else if (rst_cnt != '0) begin
            rst_cnt <= rst_cnt - RW'(1);
        end else begin
            rst_n <= 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst || game_src_c) begin
            game_rst   <= 1'b1;
            game_rst_n <= 1'b0;
            game_cnt   <= GW'(GAME_DLY);
        end else if (game_cnt != '0) begin
            game_cnt <= game_cnt - GW'(1);
        end else begin
            game_rst   <= 1'b0;
            game_rst_n <= 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            pause_state <= 1'b0;
            dip_pause   <= 1'b1;
            enable_fm   <= 1'b1;
            enable_psg  <= 1'b1;
            dip_test    <= 1'b1;
            dip_flip    <= 1'b0;
            dip_fxlevel <= 2'b10;
            LED         <= 1'b0;
        end else begin
            pause_state <= pause_nxt_c;
            dip_pause   <= ~pause_nxt_c;
            enable_fm   <= ~status[8];
            enable_psg  <= ~status[7];
            dip_test    <= ~status[6];
            dip_flip    <= status[12];
            dip_fxlevel <= status[11:10] ^ 2'b10;
            LED         <= downloading;
        end
    end

`ifdef JTFRAME_DB15_EN
    logic user_mode_nxt_c;

    assign user_mode_nxt_c = |status[31:30];

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            USER_MODE <= 1'b0;
            USER_OUT  <= 7'h7F;
        end else begin
            USER_MODE <= user_mode_nxt_c;
            USER_OUT  <= user_mode_nxt_c ? {5'b11111, joy_clk, joy_load} : 7'h7F;
        end
    end
`else
    logic unused_db15;

    assign unused_db15 = ^{joy_clk, joy_load, status[31:30]};

    always_ff @(posedge clk_sys) begin
        USER_MODE <= 1'b0;
        USER_OUT  <= 7'h7F;
    end
`endif

endmodule

// File: tb/tb_jtframe_sys_ctrl.sv
// Self-checking bench for jtframe_sys_ctrl: run-length reference model plus directed literal checks.
module tb_jtframe_sys_ctrl;

    localparam int unsigned RST_CNT  = 16;
    localparam int unsigned GAME_DLY = 256;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic        pll_locked = 1'b1;
    logic [31:0] status = '0;
    logic [1:0]  buttons = '0;
    logic        key_pause = 1'b0;
    logic        downloading = 1'b0;
    logic        joy_clk = 1'b0;
    logic        joy_load = 1'b0;
    logic        pll_rst, rst_n, game_rst, game_rst_n;
    logic        enable_fm, enable_psg, dip_test, dip_pause, dip_flip;
    logic [1:0]  dip_fxlevel;
    logic        LED;
    logic [6:0]  USER_OUT;
    logic        USER_MODE;

    int checks = 0;
    int fails  = 0;
    bit chk_en = 1'b0;

    jtframe_sys_ctrl #(.RST_CNT(RST_CNT), .GAME_DLY(GAME_DLY)) dut (
        .clk_sys(clk_sys), .rst(rst), .pll_locked(pll_locked), .status(status),
        .buttons(buttons), .key_pause(key_pause), .downloading(downloading),
        .joy_clk(joy_clk), .joy_load(joy_load), .pll_rst(pll_rst), .rst_n(rst_n),
        .game_rst(game_rst), .game_rst_n(game_rst_n), .enable_fm(enable_fm),
        .enable_psg(enable_psg), .dip_test(dip_test), .dip_pause(dip_pause),
        .dip_flip(dip_flip), .dip_fxlevel(dip_fxlevel), .LED(LED),
        .USER_OUT(USER_OUT), .USER_MODE(USER_MODE)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: resets expressed as "how long has the source been quiet"
    int       since_fall = 100000;
    int       src_run = 0;
    int       g_run = 0;
    bit       m_last = 0, m_pll_rst = 0, m_rst_n = 0, m_game_rst = 1, m_pause = 0;
    bit       m_fm = 1, m_psg = 1, m_test = 1, m_flip = 0, m_led = 0, m_umode = 0;
    bit [1:0] m_fx = 2'd2;
    bit [6:0] m_uout = 7'h7F;

    always @(posedge clk_sys) begin
        bit src, g;
        if (rst) begin
            since_fall = 100000; src_run = 0; g_run = 0;
            m_last = 0; m_pll_rst = 0; m_rst_n = 0; m_game_rst = 1; m_pause = 0;
            m_fm = 1; m_psg = 1; m_test = 1; m_flip = 0; m_fx = 2'd2; m_led = 0;
            m_umode = 0; m_uout = 7'h7F;
        end else begin
            src = !pll_locked || m_pll_rst || status[0] || buttons[1];
            g   = !m_rst_n || downloading;
            if (m_game_rst) m_pause = 0;
            else if (key_pause) m_pause = !m_pause;
            if (m_last && !pll_locked) since_fall = 0;
            else if (since_fall < 100000) since_fall++;
            m_pll_rst = (since_fall < 256);
            m_last = pll_locked;
            src_run = src ? 0 : (src_run < 100000 ? src_run + 1 : src_run);
            m_rst_n = (src_run >= RST_CNT + 1);
            g_run = g ? 0 : (g_run < 100000 ? g_run + 1 : g_run);
            m_game_rst = !(g_run >= GAME_DLY + 1);
            m_fm   = !status[8];
            m_psg  = !status[7];
            m_test = !status[6];
            m_flip = status[12];
            case (status[11:10])
                2'd0: m_fx = 2'd2;
                2'd1: m_fx = 2'd3;
                2'd2: m_fx = 2'd0;
                default: m_fx = 2'd1;
            endcase
            m_led = downloading;
`ifdef JTFRAME_DB15_EN
            m_umode = (status[31:30] != 2'b00);
            m_uout  = m_umode ? {5'b11111, joy_clk, joy_load} : 7'h7F;
`else
            m_umode = 0;
            m_uout  = 7'h7F;
`endif
        end
    end

    always @(negedge clk_sys) begin
        if (chk_en) begin
            check("pll_rst",     32'(pll_rst),     32'(m_pll_rst));
            check("rst_n",       32'(rst_n),       32'(m_rst_n));
            check("game_rst",    32'(game_rst),    32'(m_game_rst));
            check("game_rst_n",  32'(game_rst_n),  32'(!m_game_rst));
            check("enable_fm",   32'(enable_fm),   32'(m_fm));
            check("enable_psg",  32'(enable_psg),  32'(m_psg));
            check("dip_test",    32'(dip_test),    32'(m_test));
            check("dip_pause",   32'(dip_pause),   32'(!m_pause));
            check("dip_flip",    32'(dip_flip),    32'(m_flip));
            check("dip_fxlevel", 32'(dip_fxlevel), 32'(m_fx));
            check("LED",         32'(LED),         32'(m_led));
            check("USER_OUT",    32'(USER_OUT),    32'(m_uout));
            check("USER_MODE",   32'(USER_MODE),   32'(m_umode));
        end
    end

    task automatic step();
        @(posedge clk_sys);
        #2;
    endtask

    task automatic settle();
        int n = 0;
        while ((game_rst || !rst_n) && n < 3000) begin
            step();
            n++;
        end
        check("settle_timeout", 32'(n < 3000), 32'd1);
    endtask

    initial begin
        int n;
        int fx_tab[4] = '{2, 3, 0, 1};

        repeat (3) step();
        chk_en = 1'b1;
        check("rst_pll_rst",  32'(pll_rst),     32'd0);
        check("rst_rst_n",    32'(rst_n),       32'd0);
        check("rst_game_rst", 32'(game_rst),    32'd1);
        check("rst_fxlevel",  32'(dip_fxlevel), 32'd2);
        check("rst_user_out", 32'(USER_OUT),    32'h7F);

        // Power-up sequence
        rst = 1'b0;
        n = 0;
        while (!rst_n && n < 100) begin step(); n++; end
        check("rst_n_rise_cycles", 32'(n), 32'(RST_CNT + 1));
        n = 0;
        while (game_rst && n < 1000) begin step(); n++; end
        check("game_rst_fall_cycles", 32'(n), 32'(GAME_DLY + 1));
        check("pll_rst_idle", 32'(pll_rst), 32'd0);

        // One-cycle lock loss
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        n = 0;
        while (pll_rst && n < 1000) begin n++; step(); end
        check("pll_rst_width", 32'(n), 32'd256);
        settle();

        // Button reset
        buttons[1] = 1'b1;
        step();
        buttons[1] = 1'b0;
        check("button_rst_n", 32'(rst_n), 32'd0);
        settle();

        // Download holds the game in reset
        downloading = 1'b1;
        repeat (10) step();
        check("led_dl", 32'(LED), 32'd1);
        check("game_rst_dl", 32'(game_rst), 32'd1);
        downloading = 1'b0;
        n = 0;
        while (game_rst && n < 1000) begin step(); n++; end
        check("game_rst_after_dl", 32'(n), 32'(GAME_DLY + 1));

        // DIP decode
        for (int i = 0; i < 4; i++) begin
            status = 32'(i) << 10;
            step();
            check("fxlevel_map", 32'(dip_fxlevel), 32'(fx_tab[i]));
        end
        status = 32'h0000_01C0;
        step();
        check("enable_fm_off",  32'(enable_fm),  32'd0);
        check("enable_psg_off", 32'(enable_psg), 32'd0);
        check("dip_test_on",    32'(dip_test),   32'd0);
        status = 32'h0000_1000;
        step();
        check("dip_flip_on", 32'(dip_flip), 32'd1);
        status = '0;

        // Pause toggling and its suppression during game reset
        key_pause = 1'b1; step(); key_pause = 1'b0;
        check("pause_on", 32'(dip_pause), 32'd0);
        key_pause = 1'b1; step(); key_pause = 1'b0;
        check("pause_off", 32'(dip_pause), 32'd1);
        key_pause = 1'b1; step(); key_pause = 1'b0;
        downloading = 1'b1;
        step();
        step();
        check("pause_cleared_by_game_rst", 32'(dip_pause), 32'd1);
        key_pause = 1'b1; step(); key_pause = 1'b0;
        check("pause_ignored_in_game_rst", 32'(dip_pause), 32'd1);
        downloading = 1'b0;
        settle();

`ifdef JTFRAME_DB15_EN
        status = 32'h4000_0000; joy_clk = 1'b1; joy_load = 1'b0;
        step();
        check("db15_mode", 32'(USER_MODE), 32'd1);
        check("db15_out",  32'(USER_OUT),  32'h7E);
        status = '0;
        step();
        check("db15_mode_off", 32'(USER_MODE), 32'd0);
        check("db15_out_off",  32'(USER_OUT),  32'h7F);
`else
        status = 32'hC000_0000; joy_clk = 1'b1; joy_load = 1'b0;
        step();
        check("user_mode_const", 32'(USER_MODE), 32'd0);
        check("user_out_const",  32'(USER_OUT),  32'h7F);
        status = '0;
`endif

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            rst        = ($urandom_range(0, 1499) == 0);
            pll_locked = ($urandom_range(0, 1999) != 0);
            status     = $urandom;
            status[0]  = ($urandom_range(0, 499) == 0);
            buttons    = {($urandom_range(0, 499) == 0), 1'($urandom_range(0, 1))};
            key_pause  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 149) == 0) downloading = !downloading;
            joy_clk    = 1'($urandom_range(0, 1));
            joy_load   = 1'($urandom_range(0, 1));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
